// File: rtl/mem1_stage_pkg.sv
// Shared definitions for the MEM1 stage:
// bus widths, lsu_op bit positions, request FSM states.
package mem1_stage_pkg;

   localparam int EX2MEM1_WD   = 143;
   localparam int MEM12MEM2_WD = 115;
   localparam int BYPASS_WD    = 38;
   localparam int LSU_WD       = 6;

   localparam int LSU_EN = 5;
   localparam int LSU_WE = 4;
   localparam int LSU_W  = 3;
   localparam int LSU_H  = 2;
   localparam int LSU_B  = 1;
   localparam int LSU_U  = 0;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_ST_DONE = 1'b1
   } req_state_e;

   typedef struct packed {
      logic [LSU_WD-1:0] lsu_op;
      logic [2:0]        sel_rf_res;
      logic              rf_we;
      logic [4:0]        rf_waddr;
      logic [31:0]       ex_result;
      logic [31:0]       rs2_data;
      logic [31:0]       pc;
      logic [31:0]       inst;
   } ex2mem1_t;

endpackage

// File: rtl/mem1_stage_lsu_align.sv
// Byte-lane select, misalignment detect and
// store-data lane replication for one access.
module lsu_align
   import mem1_stage_pkg::*;
(
   input  logic [LSU_WD-1:0] lsu_op,
   input  logic [1:0]        addr,
   input  logic [31:0]       rs2,
   output logic [3:0]        ram_sel,
   output logic              misalign,
   output logic [31:0]       wdata
);

   logic [3:0] sel_raw;

   // decode lanes and alignment from access size
   always_comb begin
      sel_raw  = 4'b0000;
      misalign = 1'b0;
      wdata    = rs2;
      if (lsu_op[LSU_EN]) begin
         unique case (1'b1)
            lsu_op[LSU_B]: begin
               sel_raw = 4'b0001 << addr;
               wdata   = {4{rs2[7:0]}};
            end
            lsu_op[LSU_H]: begin
               sel_raw  = addr[1] ? 4'b1100 : 4'b0011;
               misalign = addr[0];
               wdata    = {2{rs2[15:0]}};
            end
            lsu_op[LSU_W]: begin
               sel_raw  = 4'b1111;
               misalign = |addr;
            end
            default: ;
         endcase
      end
   end

   assign ram_sel = misalign ? 4'b0000 : sel_raw;

endmodule

// File: rtl/mem1_stage.sv
// MEM1 stage: registers the EX result, issues the
// data-SRAM request and stalls until it is granted.
module mem1_stage
   import mem1_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [5:0]              stall,
   input  logic [EX2MEM1_WD-1:0]   ex2mem1_bus,
   output logic [MEM12MEM2_WD-1:0] mem12mem2_bus,
   output logic [BYPASS_WD-1:0]    mem12rf_bus,
   output logic                    mem1_is_load,
   output logic                    stallreq_mem1,
   output logic                    misalign,
   output logic                    misalign_store,
   output logic                    data_sram_en,
   output logic [3:0]              data_sram_we,
   output logic [31:0]             data_sram_addr,
   output logic [31:0]             data_sram_wdata,
   input  logic                    data_sram_gnt
);

   ex2mem1_t   r;
   req_state_e state;
   logic [3:0] ram_sel;
   logic       rf_we;
   logic       bubble;
   logic       unused_stall;

   assign bubble       = stall[4] & ~stall[5];
   assign unused_stall = ^stall[3:0];

   // stage register: bubble beats load beats hold
   always_ff @(posedge clk) begin
      if (!rst_n)
         r <= '0;
      else if (bubble)
         r <= '0;
      else if (!stall[4])
         r <= ex2mem1_bus;
   end

   // remember a store already written while held
   always_ff @(posedge clk) begin
      if (!rst_n || bubble)
         state <= S_IDLE;
      else begin
         unique case (state)
            S_IDLE:
               if (data_sram_en && r.lsu_op[LSU_WE]
                   && data_sram_gnt && stall[4])
                  state <= S_ST_DONE;
            S_ST_DONE:
               if (!stall[4])
                  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   lsu_align u_align (
      .lsu_op   (r.lsu_op),
      .addr     (r.ex_result[1:0]),
      .rs2      (r.rs2_data),
      .ram_sel  (ram_sel),
      .misalign (misalign),
      .wdata    (data_sram_wdata)
   );

   assign misalign_store = misalign & r.lsu_op[LSU_WE];
   assign rf_we          = r.rf_we & ~misalign;
   assign mem1_is_load   = r.sel_rf_res[1];

   assign data_sram_en   = (state == S_IDLE)
                         & r.lsu_op[LSU_EN] & ~misalign;
   assign data_sram_we   = (data_sram_en & r.lsu_op[LSU_WE])
                         ? ram_sel : 4'b0000;
   assign data_sram_addr = {r.ex_result[31:2], 2'b00};
   assign stallreq_mem1  = data_sram_en & ~data_sram_gnt;

   assign mem12mem2_bus = {r.lsu_op, ram_sel, r.sel_rf_res,
                           rf_we, r.rf_waddr, r.ex_result,
                           r.pc, r.inst};
   assign mem12rf_bus   = {rf_we, r.rf_waddr, r.ex_result};

endmodule

// File: tb/tb_mem1_stage.sv
// Directed bench for mem1_stage.
// Hand-computed vectors, immediate assertions.
module tb_mem1_stage;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [5:0]   stall;
   logic [142:0] ex2mem1_bus;
   logic [114:0] mem12mem2_bus;
   logic [37:0]  mem12rf_bus;
   logic         mem1_is_load;
   logic         stallreq_mem1;
   logic         misalign;
   logic         misalign_store;
   logic         data_sram_en;
   logic [3:0]   data_sram_we;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;
   logic         data_sram_gnt;

   int checks = 0;
   int errors = 0;
   int wecnt;

   localparam logic [5:0] OP_SB = 6'b110010;
   localparam logic [5:0] OP_SH = 6'b110100;
   localparam logic [5:0] OP_SW = 6'b111000;
   localparam logic [5:0] OP_LH = 6'b100100;
   localparam logic [5:0] OP_LW = 6'b101000;

   mem1_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall           (stall),
      .ex2mem1_bus     (ex2mem1_bus),
      .mem12mem2_bus   (mem12mem2_bus),
      .mem12rf_bus     (mem12rf_bus),
      .mem1_is_load    (mem1_is_load),
      .stallreq_mem1   (stallreq_mem1),
      .misalign        (misalign),
      .misalign_store  (misalign_store),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_gnt   (data_sram_gnt)
   );

   always #5 clk = ~clk;

   function automatic logic [142:0] mk(
      input logic [5:0]  op,
      input logic [2:0]  srf,
      input logic        we,
      input logic [4:0]  wa,
      input logic [31:0] res,
      input logic [31:0] rs2);
      return {op, srf, we, wa, res, rs2,
              32'h0000_0100, 32'h0000_0013};
   endfunction

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n         = 1'b0;
      stall         = 6'b0;
      ex2mem1_bus   = '0;
      data_sram_gnt = 1'b0;
      tick();
      tick();
      settle();
      chk("rst_bus",  128'(mem12mem2_bus), 128'h0);
      chk("rst_rf",   128'(mem12rf_bus), 128'h0);
      chk("rst_en",   128'(data_sram_en), 128'h0);
      chk("rst_sreq", 128'(stallreq_mem1), 128'h0);

      // sb 0xA5 to 0x1003
      rst_n         = 1'b1;
      data_sram_gnt = 1'b1;
      ex2mem1_bus   = mk(OP_SB, 3'b001, 1'b0, 5'd0,
                         32'h1003, 32'h0000_00A5);
      tick();
      settle();
      chk("sb_we",    128'(data_sram_we), 128'h8);
      chk("sb_wdata", 128'(data_sram_wdata), 128'hA5A5A5A5);
      chk("sb_addr",  128'(data_sram_addr), 128'h1000);
      chk("sb_sreq",  128'(stallreq_mem1), 128'h0);
      chk("sb_en",    128'(data_sram_en), 128'h1);

      // lh from 0x2002 into x5
      ex2mem1_bus = mk(OP_LH, 3'b010, 1'b1, 5'd5,
                       32'h2002, 32'h0);
      tick();
      settle();
      chk("lh_sel",  128'(mem12mem2_bus[108:105]), 128'hC);
      chk("lh_we",   128'(data_sram_we), 128'h0);
      chk("lh_load", 128'(mem1_is_load), 128'h1);
      chk("lh_rf",   128'(mem12rf_bus),
          128'({1'b1, 5'd5, 32'h2002}));

      // lw from 0x3001: misaligned
      data_sram_gnt = 1'b0;
      ex2mem1_bus   = mk(OP_LW, 3'b010, 1'b1, 5'd7,
                         32'h3001, 32'h0);
      tick();
      settle();
      chk("lw_mis",   128'(misalign), 128'h1);
      chk("lw_mst",   128'(misalign_store), 128'h0);
      chk("lw_en",    128'(data_sram_en), 128'h0);
      chk("lw_sreq",  128'(stallreq_mem1), 128'h0);
      chk("lw_rfwe2", 128'(mem12mem2_bus[101]), 128'h0);
      chk("lw_rfwe1", 128'(mem12rf_bus[37]), 128'h0);
      chk("lw_sel",   128'(mem12mem2_bus[108:105]), 128'h0);

      // sh to 0x9001: misaligned store
      ex2mem1_bus = mk(OP_SH, 3'b001, 1'b0, 5'd0,
                       32'h9001, 32'hBEEF1234);
      tick();
      settle();
      chk("sh_mis", 128'(misalign), 128'h1);
      chk("sh_mst", 128'(misalign_store), 128'h1);
      chk("sh_mwe", 128'(data_sram_we), 128'h0);

      // sh to 0x9000: low half
      data_sram_gnt = 1'b1;
      ex2mem1_bus   = mk(OP_SH, 3'b001, 1'b0, 5'd0,
                         32'h9000, 32'hBEEF1234);
      tick();
      settle();
      chk("sh_we",    128'(data_sram_we), 128'h3);
      chk("sh_wdata", 128'(data_sram_wdata), 128'h12341234);

      // sw to 0x4000, grant withheld 3 cycles
      data_sram_gnt = 1'b0;
      ex2mem1_bus   = mk(OP_SW, 3'b001, 1'b0, 5'd0,
                         32'h4000, 32'h12345678);
      tick();
      for (int i = 0; i < 3; i++) begin
         stall = 6'b111111;
         settle();
         chk("sw_wait_sreq", 128'(stallreq_mem1), 128'h1);
         tick();
      end
      stall         = 6'b0;
      data_sram_gnt = 1'b1;
      ex2mem1_bus   = '0;
      settle();
      chk("sw_gnt_sreq",  128'(stallreq_mem1), 128'h0);
      chk("sw_gnt_we",    128'(data_sram_we), 128'hF);
      chk("sw_gnt_wdata", 128'(data_sram_wdata), 128'h12345678);
      chk("sw_gnt_addr",  128'(data_sram_addr), 128'h4000);
      tick();
      settle();
      chk("sw_adv_en", 128'(data_sram_en), 128'h0);

      // sw to 0x5004 granted while held 4 cycles
      ex2mem1_bus = mk(OP_SW, 3'b001, 1'b0, 5'd0,
                       32'h5004, 32'hCAFEBABE);
      tick();
      wecnt = 0;
      for (int i = 0; i < 4; i++) begin
         stall         = 6'b110000;
         data_sram_gnt = 1'b1;
         settle();
         if (data_sram_we != 4'b0000) wecnt++;
         chk("hold_sreq", 128'(stallreq_mem1), 128'h0);
         tick();
      end
      chk("hold_wecnt", 128'(wecnt), 128'h1);
      stall       = 6'b0;
      ex2mem1_bus = mk(OP_LW, 3'b010, 1'b1, 5'd9,
                       32'h6000, 32'h0);
      settle();
      chk("done_en", 128'(data_sram_en), 128'h0);
      tick();
      settle();
      chk("idle_en",   128'(data_sram_en), 128'h1);
      chk("idle_addr", 128'(data_sram_addr), 128'h6000);
      chk("idle_load", 128'(mem1_is_load), 128'h1);

      // bubble: stall[4]=1, stall[5]=0
      stall = 6'b010000;
      tick();
      settle();
      chk("bub_bus", 128'(mem12mem2_bus), 128'h0);
      chk("bub_en",  128'(data_sram_en), 128'h0);

      // reset during a pending load
      stall         = 6'b0;
      data_sram_gnt = 1'b0;
      ex2mem1_bus   = mk(OP_LW, 3'b010, 1'b1, 5'd3,
                         32'h8000, 32'h0);
      tick();
      settle();
      chk("pend_sreq", 128'(stallreq_mem1), 128'h1);
      rst_n = 1'b0;
      tick();
      settle();
      chk("rst2_bus",  128'(mem12mem2_bus), 128'h0);
      chk("rst2_rf",   128'(mem12rf_bus), 128'h0);
      chk("rst2_en",   128'(data_sram_en), 128'h0);
      chk("rst2_sreq", 128'(stallreq_mem1), 128'h0);
      chk("rst2_addr", 128'(data_sram_addr), 128'h0);
      chk("rst2_load", 128'(mem1_is_load), 128'h0);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem1_stage.md
# mem1_stage

First memory stage of the RV32I pipeline, between EX and MEM2. It registers the EX result and derives byte lanes from the effective address. It issues the data-SRAM request so that read data returns in the following cycle, when MEM2 consumes it. It requests a pipeline stall while the data port withholds grant, and flags misaligned accesses instead of issuing them.

## Interface
- No parameters; widths come from the shared define file: `EX2MEM1_WD`=143, `MEM12MEM2_WD`=115, `BYPASS_WD`=38, `LSU_WD`=6.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- stall  in  6  pipeline stall vector; bit 4 = hold MEM1, bit 5 = hold MEM2
- ex2mem1_bus  in  143  {lsu_op[5:0], sel_rf_res[2:0], rf_we, rf_waddr[4:0], ex_result[31:0], rs2_data[31:0], pc[31:0], inst[31:0]}
- mem12mem2_bus  out  115  {lsu_op, data_ram_sel[3:0], sel_rf_res, rf_we, rf_waddr, ex_result, pc, inst}
- mem12rf_bus  out  38  {rf_we, rf_waddr, ex_result}, forwarding path
- mem1_is_load  out  1  registered instruction is a load (sel_rf_res[1]); the decoder must not forward it
- stallreq_mem1  out  1  memory request pending without grant
- misalign  out  1  registered access is misaligned; no request issued
- misalign_store  out  1  qualifies misalign: 1 = store, 0 = load
- data_sram_en  out  1  request valid
- data_sram_we  out  4  byte write enables; zero for loads
- data_sram_addr  out  32  word address {ex_result[31:2], 2'b00}
- data_sram_wdata  out  32  lane-replicated store data
- data_sram_gnt  in  1  request accepted this cycle; read data valid next cycle

## Operation
- Input register, load priority:
  - !rst_n -> 0.
  - Else stall[4] & !stall[5] -> 0 (bubble).
  - Else !stall[4] -> ex2mem1_bus.
  - Else hold.
- lsu_op = {ram_en, ram_we, size_sel[2:0] one-hot {word, half, byte}, unsigned}.
- data_ram_sel:
  - Byte: 4'b0001 << addr[1:0].
  - Half: addr[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
  - Not enabled: 0.
- Misaligned condition: half with addr[0]=1, or word with addr[1:0]≠0.
  - misalign=1; data_sram_en=0; forwarded data_ram_sel=0.
  - rf_we is forced to 0 in both output buses.
- Store data:
  - Byte: {4{rs2[7:0]}}.
  - Half: {2{rs2[15:0]}}.
  - Word: rs2.
  - data_sram_we = data_ram_sel when ram_we, else 0.
- Request FSM, two states:
  - IDLE: data_sram_en = ram_en & !misalign. stallreq_mem1 = data_sram_en & !data_sram_gnt (combinational).
  - IDLE -> ST_DONE: store granted while stall[4]=1.
  - ST_DONE: data_sram_en=0 and stallreq_mem1=0, so a held store is never re-written.
  - ST_DONE -> IDLE: when !stall[4], or on reset.
- Held loads are re-requested every cycle; this is side-effect free. Only the grant in the advancing cycle supplies MEM2's data.
- stallreq_mem1 feeds the controller, which asserts stall[4:0]. MEM1 therefore advances only in a cycle where any pending request is granted.

## Timing
- Reset values: every output is 0 and the FSM is IDLE.
- Latency: one cycle from ex2mem1_bus to mem12mem2_bus and the SRAM request. Read data arrives one cycle after grant, in MEM2.
- All SRAM outputs and stallreq_mem1 are combinational from the registered bus, FSM state and data_sram_gnt. There is no path from ex2mem1_bus.
- Bubble insertion (stall[4]&!stall[5]) clears the register and returns the FSM to IDLE in the same edge.
- Reset asserted mid-wait: the request drops next cycle; no write is issued afterwards.
- Grant arriving in the same cycle stall[4] drops (from another source): normal advance.

## Structure
- Shared define file holds `LSU_WD`, bus widths, lsu_op bit positions and FSM state encodings.
- One natural sub-module, `lsu_align`: combinational data_ram_sel, misalign and store-data replication. Reused later for AMO/store-buffer work.
- The stage register and FSM stay in mem1_stage.

## Test plan
- sb x1=0x000000A5, addr 0x1003, gnt=1 -> data_sram_we=4'b1000, wdata=0xA5A5A5A5, addr=0x1000, no stallreq.
- lh, addr 0x2002, unsigned=0 -> data_ram_sel=4'b1100 in mem12mem2_bus, data_sram_we=0, mem1_is_load=1.
- lw, addr 0x3001 -> misalign=1, misalign_store=0, data_sram_en=0, rf_we=0 in both buses.
- sw with gnt held low 3 cycles -> stallreq_mem1=1 for exactly 3 cycles, then one write. The stage advances on the grant cycle.
- sw granted while stall[4]=1 for 4 cycles (external) -> exactly one cycle with we≠0; FSM in ST_DONE until release.
- stall[4]=1, stall[5]=0 -> mem12mem2_bus=0 next cycle. rst_n=0 during a pending load -> all outputs 0 next cycle.
